// File: rtl/inv_key_generation.sv
// -----------------------------------------------------------------------------
// inv_key_generation
//   Iterative AES-128 inverse key schedule for the decryption datapath.
//   The round-10 key is loaded on start. The module then walks the key
//   schedule backwards and hands out round keys 10, 9, ..., 0 on a
//   valid/ready stream, one key per accepted beat. Each step of the
//   backwards walk is a single combinational stage, so the stream has no
//   bubbles.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    load key_in and begin (sampled only in IDLE)
//   key_in     in   128  round-10 key, word0 = [127:96]
//   key_out    out  128  current round key, word0 = [127:96]
//   round_idx  out  4    round number of key_out (10..0)
//   key_valid  out  1    key_out/round_idx valid
//   key_ready  in   1    beat accepted when key_valid & key_ready
//   busy       out  1    high while keys are being emitted
//   done       out  1    one-cycle pulse after the round-0 key is accepted
//
// Build option
//   INV_KEY_ZEROIZE_EN : when defined, the key register is cleared on the
//                        final handshake so no key material lingers in IDLE.
//                        When undefined, the round-0 key is retained.
// -----------------------------------------------------------------------------

// AES S-box computed arithmetically: multiplicative inverse in GF(2^8)
// (as x^254) followed by the affine transform.
module inv_key_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  localparam logic [7:0] AFF_C = 8'h63;

  logic [7:0] w_inv;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  assign w_inv = gf_inv(i_in);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_affine
      assign o_out[gi] = w_inv[gi]
                       ^ w_inv[(gi + 4) % 8]
                       ^ w_inv[(gi + 5) % 8]
                       ^ w_inv[(gi + 6) % 8]
                       ^ w_inv[(gi + 7) % 8]
                       ^ AFF_C[gi];
    end
  endgenerate

endmodule

module inv_key_generation #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t        r_state;
  logic [127:0]  r_key;
  logic [3:0]    r_round;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;

  logic [31:0]   w_w0, w_w1, w_w2, w_w3;
  logic [31:0]   w_p0, w_p1, w_p2, w_p3;
  logic [31:0]   w_rot;
  logic [31:0]   w_sub;
  logic [7:0]    w_rcon;
  logic [127:0]  w_prev;
  logic          w_hs;

  // Round constant of the round that produced the current key; undoing that
  // round needs the same constant the forward schedule used.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd10:   rc = 8'h36;
      4'd9:    rc = 8'h1b;
      4'd8:    rc = 8'h80;
      4'd7:    rc = 8'h40;
      4'd6:    rc = 8'h20;
      4'd5:    rc = 8'h10;
      4'd4:    rc = 8'h08;
      4'd3:    rc = 8'h04;
      4'd2:    rc = 8'h02;
      4'd1:    rc = 8'h01;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  assign w_w0 = r_key[127:96];
  assign w_w1 = r_key[95:64];
  assign w_w2 = r_key[63:32];
  assign w_w3 = r_key[31:0];

  // Words 1..3 of the previous key fall out of adjacent XORs; p3 is then
  // the previous key's last word, which feeds the g() function for p0.
  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;

  assign w_rot  = {w_p3[23:0], w_p3[31:24]};
  assign w_rcon = rcon_of(r_round);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      inv_key_sbox u_sbox (
        .i_in  (w_rot[gi*8 +: 8]),
        .o_out (w_sub[gi*8 +: 8])
      );
    end
  endgenerate

  assign w_p0   = w_w0 ^ w_sub ^ {w_rcon, 24'h000000};
  assign w_prev = {w_p0, w_p1, w_p2, w_p3};
  assign w_hs   = r_valid & key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key   <= key_in;
            r_round <= 4'(NUM_ROUNDS);
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            if (r_round == 4'd0) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
`ifdef INV_KEY_ZEROIZE_EN
              r_key   <= '0;
`endif
            end else begin
              r_key   <= w_prev;
              r_round <= r_round - 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign key_out   = r_key;
  assign round_idx = r_round;
  assign key_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_inv_key_generation.sv
// -----------------------------------------------------------------------------
// tb_inv_key_generation
//   Bench for inv_key_generation. Expected keys come from a forward AES-128
//   key expansion of a round-0 key (S-box built by brute-force inverse
//   search); the round-10 key is fed in and rounds 10..0 are expected back.
// -----------------------------------------------------------------------------
module tb_inv_key_generation;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] key_out;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  int           n_tests;
  int           n_fail;
  exp_t         q[$];
  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk [0:10];
  logic [127:0] obs [0:15];
  int           beat;
  logic         stalled;
  logic [127:0] stall_key;
  logic [3:0]   stall_round;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  inv_key_generation #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .key_out   (key_out),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = tb_xtime(aa);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [7:0] r;
    r = (b << k) | (b >> (8 - k));
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (tb_mul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Forward AES-128 expansion from the round-0 key into rk[0..10].
  task automatic expand(input logic [127:0] key0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = tb_xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_seq();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = rk[r];
      q.push_back(e);
    end
    beat = 0;
  endtask

  // One clock cycle: drive inputs, score any handshake in this cycle, advance.
  task automatic step(input logic rdy, input logic st);
    exp_t e;
    key_ready = rdy;
    start     = st;
    if (stalled) begin
      check_eq("stall_key", key_out, stall_key);
      check_eq("stall_round", 128'(round_idx), 128'(stall_round));
      check_eq("stall_valid", 128'(key_valid), 128'd1);
    end
    if (key_valid && rdy) begin
      if (q.size() == 0) begin
        check_eq("unexpected_beat", 128'(key_valid), 128'd0);
      end else begin
        e = q.pop_front();
        check_eq("key_out", key_out, e.key);
        check_eq("round_idx", 128'(round_idx), 128'(e.rnd));
        $display("[TB] beat round=%0d key=%h", round_idx, key_out);
        if (beat < 16) obs[beat] = key_out;
        beat++;
      end
    end
    stalled     = key_valid && !rdy;
    stall_key   = key_out;
    stall_round = round_idx;
    @(posedge clk);
    #1;
  endtask

  // Run until the scoreboard empties; returns cycles used.
  task automatic drain(input bit toggle, input int budget, input string tag, output int used);
    logic rdy;
    rdy  = 1'b1;
    used = 0;
    while (q.size() != 0 && used < budget) begin
      step(rdy, 1'b0);
      used++;
      if (toggle) rdy = ~rdy;
    end
    check_eq({tag, "_drained"}, 128'(q.size()), 128'd0);
    check_eq({tag, "_done"}, 128'(done), 128'd1);
    check_eq({tag, "_idle_valid"}, 128'(key_valid), 128'd0);
    check_eq({tag, "_idle_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int used;
    logic [127:0] k0;
    logic [127:0] exp_after;

    n_tests   = 0;
    n_fail    = 0;
    stalled   = 1'b0;
    beat      = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    key_ready = 1'b0;
    key_in    = '0;
    build_sbox();

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_valid", 128'(key_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_done", 128'(done), 128'd0);
    check_eq("rst_round", 128'(round_idx), 128'd0);
    check_eq("rst_key", key_out, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: FIPS-197 key, ready held high, exact latency
    expand(FIPS_K0);
    key_in = rk[10];
    push_seq();
    step(1'b1, 1'b1);
    check_eq("t1_first_valid", 128'(key_valid), 128'd1);
    check_eq("t1_first_busy", 128'(busy), 128'd1);
    drain(1'b0, 40, "t1", used);
    check_eq("t1_latency", 128'(used), 128'd11);
    check_eq("t1_beat0", obs[0], FIPS_K10);
    check_eq("t1_beat1", obs[1], FIPS_K9);
    check_eq("t1_beat9", obs[9], FIPS_K1);
    check_eq("t1_beat10", obs[10], FIPS_K0);
`ifdef INV_KEY_ZEROIZE_EN
    exp_after = '0;
`else
    exp_after = FIPS_K0;
`endif
    check_eq("t1_key_after", key_out, exp_after);
    step(1'b1, 1'b0);
    check_eq("t1_done_pulse", 128'(done), 128'd0);

    // Test 2: random key, long stall then ready toggling
    k0 = {$urandom, $urandom, $urandom, $urandom};
    expand(k0);
    key_in = rk[10];
    push_seq();
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    drain(1'b1, 60, "t2", used);

    // Test 3: start held while busy (with a junk key), then start in done cycle
    k0 = {$urandom, $urandom, $urandom, $urandom};
    expand(k0);
    key_in = rk[10];
    push_seq();
    step(1'b1, 1'b1);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1);
    check_eq("t3_done", 128'(done), 128'd1);
    check_eq("t3_q_empty", 128'(q.size()), 128'd0);
    k0 = {$urandom, $urandom, $urandom, $urandom};
    expand(k0);
    key_in = rk[10];
    push_seq();
    step(1'b1, 1'b1);
    check_eq("t3_restart_valid", 128'(key_valid), 128'd1);
    check_eq("t3_restart_round", 128'(round_idx), 128'd10);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    drain(1'b0, 40, "t3", used);

    // Test 4: reset after beat 4, then a fresh run
    k0 = {$urandom, $urandom, $urandom, $urandom};
    expand(k0);
    key_in = rk[10];
    push_seq();
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_eq("t4_pre_round", 128'(round_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    check_eq("t4_rst_valid", 128'(key_valid), 128'd0);
    check_eq("t4_rst_busy", 128'(busy), 128'd0);
    check_eq("t4_rst_round", 128'(round_idx), 128'd0);
    q.delete();
    stalled = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_seq();
    step(1'b1, 1'b1);
    check_eq("t4_fresh_round", 128'(round_idx), 128'd10);
    drain(1'b0, 40, "t4", used);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
